alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator end of the ALU command/result interface.
- Generates a programmed number of pseudo-random 10-bit ALU commands on a valid/ready link and consumes the 9-bit results returned by the ALU pipeline.
- Compares each result against an internally computed expected value, then reports pass/error counts and completion.
- Sits in front of the ALU-with-FIFOs datapath as the traffic source and checker for bring-up and self-test.

Parameters:
- EXP_DEPTH, 8: entries in the expected-result FIFO, which is also the maximum number of outstanding commands (power of 2, ≥2).
- TIMEOUT, 1024: cycles without a response in DRAIN before aborting.
- CNT_W, 16: width of num_cmds and of the pass/error counters.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request to begin a run; honoured only in IDLE
- num_cmds  in  CNT_W  commands in the run, sampled on an accepted start
- seed  in  16  LFSR seed, sampled on an accepted start
- cmd_data  out  10  command: [3:0]=a, [7:4]=b, [9:8]=op
- cmd_valid  out  1  command valid
- cmd_ready  in  1  ALU side can accept the command
- rsp_data  in  9  ALU result
- rsp_valid  in  1  result valid; always accepted, no backpressure
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse on run completion
- timeout  out  1  sticky; set when the run ended by timeout, cleared on the next start
- pass_count  out  CNT_W  matching responses
- err_count  out  CNT_W  mismatched, unexpected and missing responses
- first_err  out  18  {expected[8:0], got[8:0]} of the first mismatch in the run

Behaviour:
- Reset values (asynchronous):
  - State IDLE.
  - cmd_valid=0, cmd_data=0, busy=0, done=0, timeout=0.
  - All counters 0, first_err=0, expected FIFO empty, lfsr=16'hACE1.
  - Reset mid-run abandons the run; no done pulse.
- FSM:
  - IDLE: start=1 loads remaining=num_cmds and lfsr=seed (seed 0 is replaced by 16'hACE1), clears all counters, first_err and timeout.
    - num_cmds=0 → DONE.
    - Otherwise → ISSUE.
  - ISSUE: present the command; leave when remaining reaches 0 after an accepted command → DRAIN.
  - DRAIN: wait for the expected FIFO to be empty → DONE.
    - If TIMEOUT consecutive cycles pass with no rsp_valid, add the FIFO occupancy to err_count, set timeout, flush the FIFO, → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
  - start is ignored outside IDLE.
- Command generation, combinational from the current lfsr:
  - a=lfsr[3:0], b=lfsr[7:4], op=lfsr[9:8].
  - If op=3 and b=0, b is forced to 1 in both the issued command and the expected value.
- cmd_valid in ISSUE = remaining≠0 AND expected FIFO not full.
  - Transfer occurs when cmd_valid & cmd_ready.
  - cmd_data must be held stable while cmd_valid=1 and cmd_ready=0.
  - cmd_valid must never drop without a transfer, except on reset.
- On each transfer:
  - Push the expected result into the FIFO.
  - Decrement remaining.
  - Advance lfsr (Galois, right shift): lfsr = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- Expected result, all 9 bits, zero-extended operands:
  - op0: a+b
  - op1: (a−b) mod 512
  - op2: a*b
  - op3: a/b, integer truncation
- On rsp_valid:
  - FIFO non-empty: pop. Equal → pass_count+1. Unequal → err_count+1, and capture first_err if err_count was 0.
  - FIFO empty (unexpected response): err_count+1; counted in every state, including IDLE.
- Push and pop in the same cycle are both performed; occupancy is unchanged, and a full FIFO still accepts that push.
- Counters saturate at all-ones.
- The timeout counter resets on every rsp_valid and on entry to DRAIN.

Decomposition:
- Package alu_cmd_pkg holds:
  - op enum (ADD=0, SUB=1, MUL=2, DIV=3) and command field positions/widths.
  - LFSR_POLY=16'hB400 and LFSR_DEFAULT=16'hACE1.
  - Pure function alu_expected(a,b,op) returning 9 bits, shared with the bench model.
- One sub-module alu_exp_fifo: synchronous FIFO, EXP_DEPTH×9, with full/empty flags and simultaneous push/pop.

Test Plan:
- Seed 0xACE1, num_cmds=2, cmd_ready=1, ALU model echoes the correct result 2 cycles later:
  - First cmd_data=0x0E1 (a=1, b=14, ADD), expected 0x00F; lfsr becomes 0xE270.
  - Second cmd_data=0x270 (a=0, b=7, MUL), expected 0x000.
  - Result: done pulse, pass_count=2, err_count=0.
- cmd_ready held low for 5 cycles mid-run → cmd_valid stays 1 and cmd_data is unchanged throughout; no lfsr advance.
- No responses returned, num_cmds=20 → exactly 8 transfers, then cmd_valid=0 (FIFO full).
  - After TIMEOUT: err_count=20, not 8, because the 12 never-issued commands also count as missing (see note).
- Seed yielding a SUB with a=3, b=5: the model returns 0x1FE → pass. A corrupted model returns 0x002 → err_count=1, first_err={0x1FE,0x002}.
- DIV with b=0 generated → issued cmd has b=1, expected equals a.
- rsp_valid while IDLE → err_count+1.
- reset asserted during ISSUE → cmd_valid=0 immediately; busy=0; no done pulse.
- num_cmds=0 → done pulse 2 cycles after start, with no cmd_valid.

Note on timeout accounting: on timeout, err_count additionally adds `remaining`, so the never-issued commands count as missing.

Source files
------------

// File: rtl/alu_cmd_pkg.sv
// Shared command-format constants, op encoding, FSM states and the reference
// ALU function used by the command issuer.
package alu_cmd_pkg;

   typedef enum logic [1:0] { ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, DIV = 2'd3 } alu_op_e;
   typedef enum logic [1:0] { S_IDLE, S_ISSUE, S_DRAIN, S_DONE } issuer_state_e;

   localparam int OPND_W = 4;
   localparam int OP_W   = 2;
   localparam int CMD_W  = 10;
   localparam int RES_W  = 9;
   localparam int A_LSB  = 0;
   localparam int B_LSB  = 4;
   localparam int OP_LSB = 8;

   localparam logic [15:0] LFSR_POLY    = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

   // Galois LFSR, right-shifting
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 16'h0000);
   endfunction

   function automatic logic [RES_W-1:0] alu_expected(input logic [OPND_W-1:0] a,
                                                     input logic [OPND_W-1:0] b,
                                                     input alu_op_e op);
      logic [RES_W-1:0] ea;
      logic [RES_W-1:0] eb;
      logic [RES_W-1:0] res;
      ea  = RES_W'(a);
      eb  = RES_W'(b);
      res = '0;
      case (op)
         ADD:     res = ea + eb;
         SUB:     res = ea - eb;
         MUL:     res = ea * eb;
         default: res = (eb == '0) ? '0 : ea / eb;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/alu_exp_fifo.sv
// Expected-result FIFO: DEPTH x W, first-word-fall-through head, flush, and a
// push that is still accepted when full if a pop happens in the same cycle.
module alu_exp_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 9
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
         else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Traffic source and checker for the ALU command/result link: issues LFSR-driven
// commands, queues their expected results and scores the returned responses.
module alu_cmd_issuer
   import alu_cmd_pkg::*;
#(
   parameter int EXP_DEPTH = 8,
   parameter int TIMEOUT   = 1024,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_cmds,
   input  logic [15:0]          seed,
   output logic [CMD_W-1:0]     cmd_data,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   input  logic [RES_W-1:0]     rsp_data,
   input  logic                 rsp_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout,
   output logic [CNT_W-1:0]     pass_count,
   output logic [CNT_W-1:0]     err_count,
   output logic [2*RES_W-1:0]   first_err
);
   localparam int FW = $clog2(EXP_DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   issuer_state_e      state_reg, state_next;
   logic [CNT_W-1:0]   remaining_reg, pass_reg, err_reg;
   logic [15:0]        lfsr_reg;
   logic [2*RES_W-1:0] first_err_reg;
   logic               timeout_reg;
   logic [TW-1:0]      idle_cnt_reg;

   logic [OPND_W-1:0]  opnd_a, opnd_b, raw_b;
   alu_op_e            op;
   logic [RES_W-1:0]   exp_result, head;
   logic               fifo_full, fifo_empty;
   logic [FW-1:0]      fifo_count;
   logic               start_ok, xfer, timer_run, expire, mismatch;
   logic [CNT_W+1:0]   err_plus_missing;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Divide-by-zero is avoided at the source so the expected value stays defined
   assign opnd_a     = lfsr_reg[A_LSB +: OPND_W];
   assign raw_b      = lfsr_reg[B_LSB +: OPND_W];
   assign op         = alu_op_e'(lfsr_reg[OP_LSB +: OP_W]);
   assign opnd_b     = (op == DIV && raw_b == '0) ? OPND_W'(1) : raw_b;
   assign exp_result = alu_expected(opnd_a, opnd_b, op);

   assign cmd_valid  = (state_reg == S_ISSUE) && (remaining_reg != '0) && !fifo_full;
   assign cmd_data   = (state_reg == S_ISSUE) ? {op, opnd_b, opnd_a} : '0;
   assign xfer       = cmd_valid && cmd_ready;
   assign busy       = (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
   assign done       = (state_reg == S_DONE);
   assign start_ok   = (state_reg == S_IDLE) && start;
   assign mismatch   = (head != rsp_data);

   // A full FIFO in ISSUE can only make progress through responses, so it is watched too
   assign timer_run  = (state_reg == S_DRAIN) || ((state_reg == S_ISSUE) && fifo_full);
   assign expire     = timer_run && !rsp_valid && (idle_cnt_reg == TW'(TIMEOUT - 1));
   assign err_plus_missing = (CNT_W+2)'(err_reg) + (CNT_W+2)'(remaining_reg)
                           + (CNT_W+2)'(fifo_count);

   assign pass_count = pass_reg;
   assign err_count  = err_reg;
   assign first_err  = first_err_reg;
   assign timeout    = timeout_reg;

   alu_exp_fifo #(.DEPTH(EXP_DEPTH), .W(RES_W)) u_exp_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (expire),
      .push      (xfer),
      .push_data (exp_result),
      .pop       (rsp_valid),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start) state_next = (num_cmds == '0) ? S_DONE : S_ISSUE;
         S_ISSUE: begin
            if (expire)                                        state_next = S_DONE;
            else if (xfer && remaining_reg == CNT_W'(1))       state_next = S_DRAIN;
         end
         S_DRAIN: if (expire || fifo_empty) state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_cnt_reg <= '0;
      end else if (!timer_run || rsp_valid || (state_reg != S_DRAIN && state_next == S_DRAIN)) begin
         idle_cnt_reg <= '0;
      end else begin
         idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining_reg <= '0;
         lfsr_reg      <= LFSR_DEFAULT;
         pass_reg      <= '0;
         err_reg       <= '0;
         first_err_reg <= '0;
         timeout_reg   <= 1'b0;
      end else if (start_ok) begin
         remaining_reg <= num_cmds;
         lfsr_reg      <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
         pass_reg      <= '0;
         err_reg       <= '0;
         first_err_reg <= '0;
         timeout_reg   <= 1'b0;
      end else begin
         if (xfer) begin
            remaining_reg <= remaining_reg - 1'b1;
            lfsr_reg      <= lfsr_next(lfsr_reg);
         end
         if (rsp_valid) begin
            if (fifo_empty) begin
               err_reg <= sat_inc(err_reg);
            end else if (!mismatch) begin
               pass_reg <= sat_inc(pass_reg);
            end else begin
               err_reg <= sat_inc(err_reg);
               if (err_reg == '0) first_err_reg <= {head, rsp_data};
            end
         end
         // Queued and never-issued commands are all reported as missing
         if (expire) begin
            err_reg       <= (|err_plus_missing[CNT_W+1:CNT_W]) ? '1 : err_plus_missing[CNT_W-1:0];
            timeout_reg   <= 1'b1;
            remaining_reg <= '0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: table of runs against an ALU responder
// and an arithmetic reference model, plus reset / idle-response sequences.
module tb_alu_cmd_issuer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] num_cmds = '0;
   logic [15:0] seed = '0;
   logic [9:0]  cmd_data;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [8:0]  rsp_data = '0;
   logic        rsp_valid = 1'b0;
   logic        busy, done, timeout;
   logic [15:0] pass_count, err_count;
   logic [17:0] first_err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] seed;
      int          n;
      int          ready_mode;  // 0 always ready, 1 random, 2 stalled cycles 2..6
      int          rsp_mode;    // 0 correct, 1 none, 2 corrupted
      int          lat;
      int          exp_xfers;
      int          exp_pass;
      int          exp_err;
      bit          exp_to;
      bit          chk_first;
      logic [17:0] exp_first;
      bit          chk_cmd0;
      logic [9:0]  exp_cmd0;
   } vec_t;

   typedef struct {
      int         due;
      logic [8:0] data;
   } rsp_t;

   vec_t vecs[$];
   rsp_t rq[$];

   alu_cmd_issuer #(.EXP_DEPTH(8), .TIMEOUT(1024), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .num_cmds   (num_cmds),
      .seed       (seed),
      .cmd_data   (cmd_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .rsp_data   (rsp_data),
      .rsp_valid  (rsp_valid),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .pass_count (pass_count),
      .err_count  (err_count),
      .first_err  (first_err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_step(input logic [15:0] l);
      int h;
      h = int'(l) / 2;
      if (int'(l) % 2 == 1) h = h ^ 32'hB400;
      return 16'(h);
   endfunction

   function automatic logic [9:0] ref_cmd(input logic [15:0] l);
      int a, b, op;
      a  = int'(l) % 16;
      b  = (int'(l) / 16) % 16;
      op = (int'(l) / 256) % 4;
      if (op == 3 && b == 0) b = 1;
      return 10'(op * 256 + b * 16 + a);
   endfunction

   function automatic logic [8:0] ref_alu(input logic [9:0] c);
      int a, b, op, r;
      a  = int'(c) % 16;
      b  = (int'(c) / 16) % 16;
      op = int'(c) / 256;
      case (op)
         0:       r = a + b;
         1:       r = (a - b + 512) % 512;
         2:       r = a * b;
         default: r = (b == 0) ? 0 : a / b;
      endcase
      return 9'(r);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic add_vec(input logic [15:0] s, input int n, input int rm, input int pm,
                          input int lat, input int xf, input int ps, input int er,
                          input bit to, input bit cf, input logic [17:0] fe,
                          input bit cc, input logic [9:0] c0);
      vec_t v;
      v.seed = s; v.n = n; v.ready_mode = rm; v.rsp_mode = pm; v.lat = lat;
      v.exp_xfers = xf; v.exp_pass = ps; v.exp_err = er; v.exp_to = to;
      v.chk_first = cf; v.exp_first = fe; v.chk_cmd0 = cc; v.exp_cmd0 = c0;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [15:0] l;
      logic [9:0]  pc, held;
      int          k, xfers, done_k;
      bit          got_done, hold, saw_valid;
      rsp_t        r;
      rq.delete();
      l = (v.seed == 16'h0000) ? 16'hACE1 : v.seed;
      k = 0; xfers = 0; done_k = -1; got_done = 0; hold = 0; saw_valid = 0; held = '0;
      start = 1'b1; num_cmds = 16'(v.n); seed = v.seed;
      while (!got_done && k < 6000) begin
         case (v.ready_mode)
            0:       cmd_ready = 1'b1;
            1:       cmd_ready = ($urandom_range(0, 3) != 0);
            default: cmd_ready = !(k >= 2 && k <= 6);
         endcase
         rsp_valid = 1'b0;
         rsp_data  = '0;
         if (rq.size() > 0 && rq[0].due == k) begin
            rsp_valid = 1'b1;
            rsp_data  = rq[0].data;
            rq.delete(0);
         end
         if (k == 1 && v.n > 0) chk("busy_in_run", 32'(busy), 32'd1);
         if (v.ready_mode == 2 && k >= 2 && k <= 6) chk("stall_valid", 32'(cmd_valid), 32'd1);
         if (hold) begin
            chk("hold_valid", 32'(cmd_valid), 32'd1);
            chk("hold_data", 32'(cmd_data), 32'(held));
         end
         if (cmd_valid) saw_valid = 1;
         if (done) begin
            got_done = 1;
            done_k   = k;
         end
         if (cmd_valid && cmd_ready) begin
            pc = ref_cmd(l);
            if (xfers == 0 && v.chk_cmd0) chk("cmd0", 32'(cmd_data), 32'(v.exp_cmd0));
            chk("cmd_data", 32'(cmd_data), 32'(pc));
            l = ref_step(l);
            xfers++;
            if (v.rsp_mode != 1) begin
               r.due  = k + v.lat;
               r.data = (v.rsp_mode == 2) ? (ref_alu(cmd_data) ^ 9'h1FC) : ref_alu(cmd_data);
               rq.push_back(r);
            end
         end
         hold = cmd_valid && !cmd_ready;
         held = cmd_data;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         k++;
      end
      rsp_valid = 1'b0;
      chk("done_seen", 32'(got_done), 32'd1);
      chk("done_pulse_end", 32'(done), 32'd0);
      chk("xfers", 32'(xfers), 32'(v.exp_xfers));
      chk("pass_count", 32'(pass_count), 32'(v.exp_pass));
      chk("err_count", 32'(err_count), 32'(v.exp_err));
      chk("timeout", 32'(timeout), 32'(v.exp_to));
      if (v.chk_first) chk("first_err", 32'(first_err), 32'(v.exp_first));
      if (v.n == 0) begin
         chk("zero_no_valid", 32'(saw_valid), 32'd0);
         chk("zero_done_early", 32'(done_k >= 1 && done_k <= 2), 32'd1);
      end
      $display("run %0d seed=%h n=%0d xfers=%0d pass=%0d err=%0d timeout=%0b done_at=%0d",
               idx, v.seed, v.n, xfers, pass_count, err_count, timeout, done_k);
   endtask

   initial begin
      logic [15:0] s;
      logic [9:0]  c0;
      logic [8:0]  r0;
      int          n, lat;
      bit          seen;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_cmd_data", 32'(cmd_data), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_pass", 32'(pass_count), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_first_err", 32'(first_err), 32'd0);

      add_vec(16'hACE1,  2, 0, 0, 2,  2, 2,  0, 0, 1, 18'h0,     1, 10'h0E1);
      add_vec(16'hACE1,  4, 2, 0, 2,  4, 4,  0, 0, 1, 18'h0,     1, 10'h0E1);
      add_vec(16'h0153,  1, 0, 0, 2,  1, 1,  0, 0, 1, 18'h0,     1, 10'h153);
      add_vec(16'h0153,  1, 0, 2, 2,  1, 0,  1, 0, 1, 18'h3FC02, 1, 10'h153);
      add_vec(16'h0309,  1, 0, 0, 2,  1, 1,  0, 0, 1, 18'h0,     1, 10'h319);
      add_vec(16'h0000,  5, 1, 0, 3,  5, 5,  0, 0, 1, 18'h0,     1, 10'h0E1);
      add_vec(16'hACE1, 20, 0, 1, 2,  8, 0, 20, 1, 1, 18'h0,     1, 10'h0E1);
      add_vec(16'h1234,  6, 0, 0, 1,  6, 6,  0, 0, 1, 18'h0,     0, 10'h0);
      for (int i = 0; i < 4; i++) begin
         s   = 16'($urandom);
         n   = $urandom_range(1, 40);
         lat = $urandom_range(1, 12);
         add_vec(s, n, 1, 0, lat, n, n, 0, 0, 1, 18'h0, 0, 10'h0);
      end
      s  = 16'($urandom);
      n  = $urandom_range(2, 30);
      c0 = ref_cmd((s == 16'h0000) ? 16'hACE1 : s);
      r0 = ref_alu(c0);
      add_vec(s, n, 1, 2, 4, n, 0, n, 0, 1, {r0, r0 ^ 9'h1FC}, 1, c0);
      add_vec(16'hBEEF, 0, 0, 0, 2, 0, 0, 0, 0, 1, 18'h0, 0, 10'h0);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // unexpected responses while idle (last run ended with zero errors)
      for (int i = 1; i <= 2; i++) begin
         rsp_valid = 1'b1;
         rsp_data  = 9'h055;
         @(negedge clk);
         rsp_valid = 1'b0;
         chk("idle_rsp_err", 32'(err_count), 32'(i));
         $display("idle response %0d err=%0d", i, err_count);
      end

      // reset in the middle of ISSUE
      cmd_ready = 1'b0;
      start = 1'b1; num_cmds = 16'd10; seed = 16'hACE1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_valid", 32'(cmd_valid), 32'd1);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_valid", 32'(cmd_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_data", 32'(cmd_data), 32'd0);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      reset = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("midrst_no_done", 32'(seen), 32'd0);
      chk("midrst_err", 32'(err_count), 32'd0);
      chk("midrst_idle_valid", 32'(cmd_valid), 32'd0);
      $display("reset during issue: done_seen=%0b busy=%0b", seen, busy);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
